// File: rtl/regfile_pkg.sv
// Shared sizing constants and word/address types for the
// 256 x 8 synchronous register file.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Zero word used for clears and the reset value of the read register.
    localparam word_t WORD_ZERO = '0;

endpackage

// File: rtl/regfile_storage.sv
// DEPTH x DATA_W storage array: synchronous clear, one synchronous
// write port and a combinational read of the addressed word.
module regfile_storage
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    word_t mem [DEPTH];

    // Clear wipes every word; otherwise a qualified write updates one word.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WORD_ZERO;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read sees the contents before any write on the current edge.
    assign rdata = mem[addr];

endmodule

// File: rtl/regfile.sv
// 256 x 8 single-port register file with registered read data.
// Macro REGFILE_BYPASS_EN: write+read on one edge returns the new data.
module regfile
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              CS,
    input  logic              WE,
    input  logic              RD,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut
);

    logic  wr_en;
    logic  rd_en;
    word_t mem_word;
    word_t rd_word;
    word_t out_q;

    assign wr_en = CS & WE;
    assign rd_en = CS & RD;

    regfile_storage u_storage (
        .clk   (Clk),
        .clr   (Rst),
        .we    (wr_en),
        .addr  (Addr),
        .wdata (dataIn),
        .rdata (mem_word)
    );

    // Select the word captured by a read on this edge.
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_word = mem_word;
        if (wr_en) begin
            rd_word = dataIn;
        end
    end
`else
    always_comb begin
        rd_word = mem_word;
    end
`endif

    // Read register: cleared by reset, loaded on a qualified read, else held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_q <= WORD_ZERO;
        end else if (rd_en) begin
            out_q <= rd_word;
        end
    end

    assign dataOut = out_q;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected dataOut values,
// a monitor pops and compares them just after the sampling edge.
module tb_regfile;

    logic       Clk;
    logic       Rst;
    logic       CS;
    logic       WE;
    logic       RD;
    logic [7:0] Addr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;

    logic       chk;
    logic [7:0] exp_q [$];
    string      name_q [$];
    logic [7:0] e;
    string      nm;
    int         checks;
    int         errors;

    regfile dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .CS      (CS),
        .WE      (WE),
        .RD      (RD),
        .Addr    (Addr),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: a flagged edge presents one expected value on dataOut.
    always @(posedge Clk) begin
        if (chk) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got %02h, no expectation", dataOut);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (dataOut !== e) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h", nm, dataOut, e);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic cs, input logic we,
                       input logic rd, input logic [7:0] a,
                       input logic [7:0] d, input logic c,
                       input logic [7:0] x, input string n);
        @(negedge Clk);
        Rst    = rst;
        CS     = cs;
        WE     = we;
        RD     = rd;
        Addr   = a;
        dataIn = d;
        chk    = c;
        if (c) begin
            exp_q.push_back(x);
            name_q.push_back(n);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(0, 1, 1, 0, a, d, 0, 8'h00, "");
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] x,
                      input string n);
        cyc(0, 1, 0, 1, a, 8'h00, 1, x, n);
    endtask

    logic [7:0] wa [5];
    logic [7:0] wd [5];
    logic [7:0] sim_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        chk = 0; Rst = 1; CS = 0; WE = 0; RD = 0; Addr = 0; dataIn = 0;
        wa = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        wd = '{8'h00, 8'h01, 8'h10, 8'h06, 8'h12};
`ifdef REGFILE_BYPASS_EN
        sim_exp = 8'hA5;
`else
        sim_exp = 8'h06;
`endif

        cyc(1, 0, 0, 0, 8'd0, 8'd0, 1, 8'h00, "reset_out");

        // 1. reset clears loaded data
        for (int i = 0; i < 5; i++) wr(8'(i), 8'(8'h11 + i));
        rd(8'd2, 8'h13, "preload_rd2");
        cyc(1, 0, 0, 0, 8'd0, 8'd0, 1, 8'h00, "reset_pulse_out");
        for (int i = 0; i < 5; i++) rd(8'(i), 8'h00, "reset_mem");

        // 2. write then read back
        for (int i = 0; i < 5; i++) wr(wa[i], wd[i]);
        for (int i = 0; i < 5; i++) rd(wa[i], wd[i], "readback");

        // 3. chip select gating
        cyc(0, 0, 1, 0, 8'd2, 8'hFF, 1, 8'h12, "cs0_write_hold");
        rd(8'd2, 8'h10, "cs0_write_ignored");
        cyc(0, 0, 0, 1, 8'd4, 8'h00, 1, 8'h10, "cs0_read_hold");

        // 4. hold with CS=1, RD=0, WE=0
        rd(8'd3, 8'h06, "hold_src");
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 0, 8'(i), 8'hEE, 1, 8'h06, "hold");

        // 5. simultaneous write and read
        cyc(0, 1, 1, 1, 8'd3, 8'hA5, 1, sim_exp, "simul_rw");
        rd(8'd3, 8'hA5, "simul_after");

        // 6. boundary addresses and reset priority
        wr(8'd255, 8'h5A);
        wr(8'd0, 8'hC3);
        rd(8'd255, 8'h5A, "addr255");
        rd(8'd0, 8'hC3, "addr0");
        cyc(1, 1, 1, 1, 8'd7, 8'h77, 1, 8'h00, "rst_prio_out");
        rd(8'd7, 8'h00, "rst_prio_mem");
        rd(8'd255, 8'h00, "rst_clr255");

        cyc(0, 0, 0, 0, 8'd0, 8'd0, 0, 8'h00, "");
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
